// File: rtl/uc_port_monitor.sv
// rtl/uc_port_monitor.sv - per-unit port reduction, change counter and snapshot streamer for the uC array
module uc_port_monitor #(
    parameter int UNIT_COUNT = 35,
    parameter int PORT_W     = 8,
    parameter int NUM_PORTS  = 3,
    parameter int IDX_W      = (UNIT_COUNT > 1) ? $clog2(UNIT_COUNT) : 1
) (
    input  logic                                clock,
    input  logic                                resetn,
    input  logic [UNIT_COUNT*NUM_PORTS*PORT_W-1:0] port_in,
    input  logic [1:0]                          mode,
    output logic [UNIT_COUNT*NUM_PORTS-1:0]     red_out,
    input  logic                                cnt_clr,
    output logic [15:0]                         chg_count,
    input  logic                                snap_req,
    output logic                                snap_busy,
    output logic                                rd_valid,
    input  logic                                rd_ready,
    output logic [PORT_W-1:0]                   rd_data,
    output logic [IDX_W-1:0]                    rd_unit,
    output logic [1:0]                          rd_port,
    output logic                                rd_last
);
    localparam int               N_BYTES       = UNIT_COUNT * NUM_PORTS;
    localparam logic [IDX_W-1:0] LAST_UNIT     = IDX_W'(UNIT_COUNT - 1);
    localparam logic [1:0]       LAST_PORT     = 2'(NUM_PORTS - 1);
    localparam logic             FIRST_IS_LAST = (N_BYTES == 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_STREAM
    } state_t;

    state_t                      state;
    state_t                      state_nxt;
    logic [N_BYTES*PORT_W-1:0]   cap_reg;
    logic [PORT_W-1:0]           snap_buf [UNIT_COUNT][NUM_PORTS];
    logic [N_BYTES-1:0]          red_nxt;
    logic                        accept;
    logic [IDX_W-1:0]            unit_nxt;
    logic [1:0]                  port_nxt;
    logic                        last_nxt;

    assign snap_busy = (state != S_IDLE);

    // FREEZE keeps red_out; any other mode reduces each captured byte independently
    always_comb begin
        red_nxt = red_out;
        for (int i = 0; i < N_BYTES; i++) begin
            case (mode)
                2'b00:   red_nxt[i] = ^cap_reg[i*PORT_W +: PORT_W];
                2'b01:   red_nxt[i] = |cap_reg[i*PORT_W +: PORT_W];
                2'b10:   red_nxt[i] = &cap_reg[i*PORT_W +: PORT_W];
                default: red_nxt[i] = red_out[i];
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = rd_valid && rd_ready;
        unit_nxt  = rd_unit;
        port_nxt  = rd_port + 2'd1;
        if (rd_port == LAST_PORT) begin
            port_nxt = 2'd0;
            unit_nxt = rd_unit + 1'b1;
        end
        last_nxt = (unit_nxt == LAST_UNIT) && (port_nxt == LAST_PORT);
        case (state)
            S_IDLE:    if (snap_req) state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = S_STREAM;
            S_STREAM:  if (accept && rd_last) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            cap_reg   <= '0;
            red_out   <= '0;
            chg_count <= '0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            rd_unit   <= '0;
            rd_port   <= '0;
            rd_last   <= 1'b0;
            for (int u = 0; u < UNIT_COUNT; u++) begin
                for (int p = 0; p < NUM_PORTS; p++) begin
                    snap_buf[u][p] <= '0;
                end
            end
        end else begin
            cap_reg <= port_in;
            red_out <= red_nxt;
            if (cnt_clr) begin
                chg_count <= '0;
            end else if ((red_nxt != red_out) && (chg_count != 16'hFFFF)) begin
                chg_count <= chg_count + 16'd1;
            end

            case (state)
                S_CAPTURE: begin
                    for (int u = 0; u < UNIT_COUNT; u++) begin
                        for (int p = 0; p < NUM_PORTS; p++) begin
                            snap_buf[u][p] <= cap_reg[(u*NUM_PORTS + p)*PORT_W +: PORT_W];
                        end
                    end
                    rd_valid <= 1'b1;
                    rd_data  <= cap_reg[PORT_W-1:0];
                    rd_unit  <= '0;
                    rd_port  <= '0;
                    rd_last  <= FIRST_IS_LAST;
                end
                S_STREAM: begin
                    // outputs stay put while the consumer stalls; advance only on accept
                    if (accept) begin
                        if (rd_last) begin
                            rd_valid <= 1'b0;
                        end else begin
                            rd_unit <= unit_nxt;
                            rd_port <= port_nxt;
                            rd_data <= snap_buf[unit_nxt][port_nxt];
                            rd_last <= last_nxt;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uc_port_monitor.sv
// tb/tb_uc_port_monitor.sv - self-checking bench for uc_port_monitor
module tb_uc_port_monitor;
    localparam int UC = 2;
    localparam int NP = 3;
    localparam int PW = 8;
    localparam int NB = UC * NP;

    logic              clock = 1'b0;
    logic              resetn;
    logic [NB*PW-1:0]  port_in;
    logic [1:0]        mode;
    logic [NB-1:0]     red_out;
    logic              cnt_clr;
    logic [15:0]       chg_count;
    logic              snap_req;
    logic              snap_busy;
    logic              rd_valid;
    logic              rd_ready;
    logic [PW-1:0]     rd_data;
    logic [0:0]        rd_unit;
    logic [1:0]        rd_port;
    logic              rd_last;

    int errors = 0;
    int checks = 0;
    logic model_en = 1'b0;
    logic chk_en = 1'b0;

    always #5 clock = ~clock;

    uc_port_monitor #(.UNIT_COUNT(UC), .PORT_W(PW), .NUM_PORTS(NP)) dut (
        .clock(clock), .resetn(resetn), .port_in(port_in), .mode(mode),
        .red_out(red_out), .cnt_clr(cnt_clr), .chg_count(chg_count),
        .snap_req(snap_req), .snap_busy(snap_busy), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .rd_data(rd_data), .rd_unit(rd_unit),
        .rd_port(rd_port), .rd_last(rd_last)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: byte-wise reductions by counting ones, snapshot as a flat entry index
    logic [NB*PW-1:0] m_cap = '0;
    logic [NB*PW-1:0] m_pend = '0;
    logic [NB*PW-1:0] m_snap = '0;
    logic [NB-1:0]    m_red = '0;
    int               m_cnt = 0;
    int               m_phase = 0;
    int               m_pos = 0;

    always @(posedge clock) begin : ref_model
        logic [NB-1:0] nr;
        logic [PW-1:0] bv;
        if (model_en) begin
            if (!resetn) begin
                m_cap <= '0; m_pend <= '0; m_snap <= '0; m_red <= '0;
                m_cnt <= 0; m_phase <= 0; m_pos <= 0;
            end else begin
                nr = m_red;
                if (mode != 2'b11) begin
                    for (int b = 0; b < NB; b++) begin
                        bv = m_cap[b*PW +: PW];
                        if (mode == 2'b00)      nr[b] = ($countones(bv) % 2) == 1;
                        else if (mode == 2'b01) nr[b] = (bv != '0);
                        else                    nr[b] = (bv == 8'hFF);
                    end
                end
                if (cnt_clr) m_cnt <= 0;
                else if (nr != m_red && m_cnt < 65535) m_cnt <= m_cnt + 1;
                m_red <= nr;
                m_cap <= port_in;
                case (m_phase)
                    0: if (snap_req) begin m_phase <= 1; m_pend <= port_in; end
                    1: begin m_phase <= 2; m_snap <= m_pend; m_pos <= 0; end
                    default: if (rd_ready) begin
                        if (m_pos == NB-1) m_phase <= 0;
                        else m_pos <= m_pos + 1;
                    end
                endcase
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("rnd_red", red_out, m_red);
            check("rnd_cnt", chg_count, m_cnt);
            check("rnd_busy", snap_busy, m_phase != 0);
            check("rnd_valid", rd_valid, m_phase == 2);
            if (m_phase == 2)
                check("rnd_entry", {rd_data, rd_unit, rd_port, rd_last},
                      {m_snap[m_pos*PW +: PW], 1'(m_pos / NP), 2'(m_pos % NP), 1'(m_pos == NB-1)});
        end
    end

    task automatic trigger(input logic [NB*PW-1:0] val, input string tag);
        port_in  = val;
        snap_req = 1'b1;
        @(posedge clock); @(negedge clock);
        snap_req = 1'b0;
        check({tag, "_busy_capture"}, snap_busy, 1);
        check({tag, "_valid_capture"}, rd_valid, 0);
    endtask

    task automatic run_stream(input logic [NB*PW-1:0] snap, input int stall_at,
                              input int stall_len, input int n_acc, input string tag);
        int k = 0;
        int waits = 0;
        int st = 0;
        logic seen = 1'b0;
        for (int cyc = 0; cyc < 60 && k < n_acc; cyc++) begin
            if (rd_valid) begin
                if (!seen) begin
                    check({tag, "_first_valid_gap"}, waits, 1);
                    seen = 1'b1;
                end
                check({tag, "_entry"}, {rd_data, rd_unit, rd_port, rd_last},
                      {snap[k*PW +: PW], 1'(k / NP), 2'(k % NP), 1'(k == NB-1)});
                if (k == stall_at && st < stall_len) begin
                    rd_ready = 1'b0;
                    st++;
                    port_in  = {16'($urandom()), $urandom()};
                    snap_req = 1'b1;
                end else begin
                    rd_ready = 1'b1;
                    snap_req = 1'b0;
                    k++;
                end
            end else begin
                if (!seen) waits++;
                rd_ready = 1'b1;
            end
            @(posedge clock); @(negedge clock);
        end
        check({tag, "_accepts"}, k, n_acc);
    endtask

    typedef struct {
        logic [23:0] u0;
        logic [1:0]  md;
        logic [2:0]  exp;
    } red_vec_t;

    red_vec_t vecs[8];

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{24'h00FF01, 2'b00, 3'b001};
        vecs[1] = '{24'h00FF01, 2'b10, 3'b010};
        vecs[2] = '{24'h00FF01, 2'b01, 3'b011};
        vecs[3] = '{24'h0700FE, 2'b11, 3'b011};
        vecs[4] = '{24'h0700FE, 2'b00, 3'b101};
        vecs[5] = '{24'hFFFFFF, 2'b10, 3'b111};
        vecs[6] = '{24'h000000, 2'b01, 3'b000};
        vecs[7] = '{24'h038000, 2'b00, 3'b010};

        resetn = 1'b0; port_in = '1; mode = 2'b00; cnt_clr = 1'b0;
        snap_req = 1'b0; rd_ready = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset_red", red_out, 0);
        check("reset_cnt", chg_count, 0);
        check("reset_valid", rd_valid, 0);
        check("reset_busy", snap_busy, 0);
        check("reset_data", rd_data, 0);
        resetn = 1'b1;

        for (int i = 0; i < 8; i++) begin
            port_in = {24'h0, vecs[i].u0};
            mode    = vecs[i].md;
            @(posedge clock); @(posedge clock); @(negedge clock);
            check($sformatf("red_vec%0d", i), red_out, {3'b000, vecs[i].exp});
        end

        port_in = '0; mode = 2'b00;
        repeat (3) @(posedge clock);
        @(negedge clock); cnt_clr = 1'b1;
        @(posedge clock); @(negedge clock); cnt_clr = 1'b0;
        check("cnt_cleared", chg_count, 0);
        for (int k = 0; k < 10; k++) begin
            port_in[24] = ~port_in[24];
            @(posedge clock); @(negedge clock);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("cnt_ten", chg_count, 10);

        port_in[24] = 1'b1;
        @(posedge clock); @(negedge clock); cnt_clr = 1'b1;
        @(posedge clock); @(negedge clock); cnt_clr = 1'b0;
        check("clr_on_change_cnt", chg_count, 0);
        check("clr_on_change_red", red_out[3], 1);
        @(posedge clock); @(negedge clock);
        check("clr_hold", chg_count, 0);

        force dut.chg_count = 16'hFFFD;
        #1;
        release dut.chg_count;
        port_in[24] = 1'b0;
        @(posedge clock); @(posedge clock); @(negedge clock);
        check("cnt_fffe", chg_count, 16'hFFFE);
        for (int k = 0; k < 4; k++) begin
            port_in[24] = ~port_in[24];
            @(posedge clock); @(negedge clock);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("cnt_saturate", chg_count, 16'hFFFF);

        resetn = 1'b0;
        @(posedge clock); @(negedge clock);
        resetn = 1'b1; rd_ready = 1'b1;
        @(posedge clock); @(negedge clock);

        trigger(48'h151413121110, "s4");
        run_stream(48'h151413121110, -1, 0, NB, "s4");
        check("s4_end_valid", rd_valid, 0);
        check("s4_end_busy", snap_busy, 0);

        trigger(48'h151413121110, "s5");
        run_stream(48'h151413121110, 2, 3, NB, "s5");
        check("s5_end_valid", rd_valid, 0);
        check("s5_end_busy", snap_busy, 0);
        @(posedge clock); @(negedge clock);
        check("s5_no_queued_req", snap_busy, 0);

        trigger(48'hA5A4A3A2A1A0, "s6a");
        run_stream(48'hA5A4A3A2A1A0, -1, 0, 3, "s6a");
        resetn = 1'b0;
        @(posedge clock); @(negedge clock);
        check("s6_reset_valid", rd_valid, 0);
        check("s6_reset_busy", snap_busy, 0);
        resetn = 1'b1;
        trigger(48'hB5B4B3B2B1B0, "s6b");
        run_stream(48'hB5B4B3B2B1B0, -1, 0, NB, "s6b");
        check("s6b_end_busy", snap_busy, 0);

        model_en = 1'b1; resetn = 1'b0;
        @(posedge clock);
        #1 chk_en = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clock);
            resetn = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 1) == 0) begin
                for (int b = 0; b < NB; b++) begin
                    case ($urandom_range(0, 3))
                        0:       port_in[b*PW +: PW] = 8'h00;
                        1:       port_in[b*PW +: PW] = 8'hFF;
                        default: port_in[b*PW +: PW] = 8'($urandom());
                    endcase
                end
            end
            mode     = 2'($urandom_range(0, 3));
            cnt_clr  = ($urandom_range(0, 15) == 0);
            snap_req = ($urandom_range(0, 7) == 0);
            rd_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clock);
        #1 chk_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
